// File: rtl/triad_scheduler_pkg.sv
// Shared widths and types for the triad result scheduler: triad payload and
// timestamp widths, the buffered slot word layout and the arbiter state type.
package triad_scheduler_pkg;

  localparam int TRIAD_DATA_W = 68;
  localparam int TS_W         = 24;
  // A buffered slot word is {ts, triad_data}; out_data prepends the triad id.
  localparam int SLOT_W       = TS_W + TRIAD_DATA_W;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_e;

  function automatic int id_width(input int nb_triads);
    return (nb_triads < 2) ? 1 : $clog2(nb_triads);
  endfunction

endpackage

// File: rtl/triad_slot.sv
// Per-triad front end: one buffered result word with a sticky overflow flag,
// a silence watchdog, and the re-arm pulse that drives reset_pulse_identifier.
module triad_slot
  import triad_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 960000,
  parameter int RST_PULSE_LEN  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    data_avl_i,
  input  logic [TRIAD_DATA_W-1:0] triad_data_i,
  input  logic [TS_W-1:0]         sys_ts_i,
  input  logic                    drain_i,
  output logic                    slot_valid_o,
  output logic [SLOT_W-1:0]       slot_word_o,
  output logic                    overflow_o,
  output logic                    reset_pulse_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PL_W = $clog2(RST_PULSE_LEN + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PL_W-1:0] PL_LOAD = PL_W'(RST_PULSE_LEN);

  logic              valid_q, valid_d;
  logic [SLOT_W-1:0] word_q,  word_d;
  logic              ovf_q,   ovf_d;
  logic [WD_W-1:0]   wd_q,    wd_d;
  logic [PL_W-1:0]   pcnt_q,  pcnt_d;
  logic              pulse_active;
  logic              wd_fire;

  assign pulse_active = (pcnt_q != '0);

  // A drain in the same cycle frees the slot, so a coincident strobe is kept.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    ovf_d   = ovf_q;
    if (data_avl_i) begin
      if (!valid_q || drain_i) begin
        valid_d = 1'b1;
        word_d  = {sys_ts_i, triad_data_i};
      end else begin
        ovf_d = 1'b1;
      end
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    wd_fire = 1'b0;
    wd_d    = wd_q;
    pcnt_d  = pcnt_q;
    if (data_avl_i || pulse_active) begin
      wd_d = '0;
    end else if (wd_q == WD_LAST) begin
      wd_d    = '0;
      wd_fire = 1'b1;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
    // Any new trigger restarts the pulse, even one already in progress.
    if (data_avl_i || wd_fire) begin
      pcnt_d = PL_LOAD;
    end else if (pulse_active) begin
      pcnt_d = pcnt_q - PL_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      ovf_q   <= 1'b0;
      wd_q    <= '0;
      pcnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
      wd_q    <= wd_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign slot_valid_o  = valid_q;
  assign slot_word_o   = word_q;
  assign overflow_o    = ovf_q;
  assign reset_pulse_o = pulse_active;

endmodule

// File: rtl/triad_scheduler.sv
// Gathers one buffered result per triad and round-robins them onto a single
// valid/ready output stream toward the host link.
module triad_scheduler
  import triad_scheduler_pkg::*;
#(
  parameter  int NB_TRIADS      = 4,
  parameter  int TIMEOUT_CYCLES = 960000,
  parameter  int RST_PULSE_LEN  = 4,
  localparam int ID_W           = id_width(NB_TRIADS),
  localparam int OUT_W          = ID_W + SLOT_W
) (
  input  logic                              clk_96MHz,
  input  logic                              reset,
  input  logic [NB_TRIADS-1:0]              data_avl,
  input  logic [TRIAD_DATA_W*NB_TRIADS-1:0] triad_data,
  input  logic [TS_W-1:0]                   sys_ts,
  output logic [NB_TRIADS-1:0]              reset_pulse_identifier,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_W-1:0]                  out_data,
  output logic [NB_TRIADS-1:0]              overflow,
  output logic                              state_led,
  output arb_state_e                        dbg_state_o
);

  logic [NB_TRIADS-1:0] slot_valid;
  logic [SLOT_W-1:0]    slot_word [NB_TRIADS];
  logic [NB_TRIADS-1:0] drain;

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   rr_next;

  for (genvar g = 0; g < NB_TRIADS; g++) begin : g_slot
    triad_slot #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .RST_PULSE_LEN  (RST_PULSE_LEN)
    ) u_slot (
      .clk_i         (clk_96MHz),
      .rst_i         (reset),
      .data_avl_i    (data_avl[g]),
      .triad_data_i  (triad_data[TRIAD_DATA_W*g +: TRIAD_DATA_W]),
      .sys_ts_i      (sys_ts),
      .drain_i       (drain[g]),
      .slot_valid_o  (slot_valid[g]),
      .slot_word_o   (slot_word[g]),
      .overflow_o    (overflow[g]),
      .reset_pulse_o (reset_pulse_identifier[g])
    );
  end

  // First valid slot at or after the round-robin pointer, wrapping to 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_q;
    cand        = '0;
    for (int k = 0; k < NB_TRIADS; k++) begin
      cand = ID_W'((int'(rr_q) + k) % NB_TRIADS);
      if (!grant_found && slot_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign rr_next = (grant_q == ID_W'(NB_TRIADS - 1)) ? '0 : grant_q + ID_W'(1);

  // Output handshake: out_valid rises with a freshly loaded word and then
  // holds, with out_data frozen, until a cycle where out_valid && out_ready;
  // the word is consumed on that edge and the arbiter returns to IDLE.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    out_data_d = out_data_q;
    drain      = '0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_found) begin
          drain[grant_idx] = 1'b1;
          out_data_d       = {grant_idx, slot_word[grant_idx]};
          grant_d          = grant_idx;
          state_d          = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        if (out_ready) begin
          rr_d    = rr_next;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_96MHz or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      rr_q       <= '0;
      grant_q    <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid   = (state_q == ARB_OFFER);
  assign out_data    = out_data_q;
  assign state_led   = |overflow;
  assign dbg_state_o = state_q;

endmodule
